// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N:1 packet-locked stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam int MIN_CH = 2;

    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Low bit of channel ch inside the flattened s_data bus.
    function automatic int ch_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Single-stage valid/ready register; loads and drains in the same cycle for full throughput.
module stream_reg_slice #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 registered stream mux; the select is locked for the duration of a packet.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        s_valid,
    input  logic [N_CH*DATA_W-1:0] s_data,
    input  logic [N_CH-1:0]        s_last,
    output logic [N_CH-1:0]        s_ready,
    output logic                   m_valid,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   busy,
    output logic [SEL_W-1:0]       cur_sel
);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   lock_sel;
    logic [SEL_W-1:0]   active;
    logic               in_range, free, grant_ok, hs;
    logic               sel_valid, sel_last;
    logic [DATA_W-1:0]  sel_data;

    assign active   = (state == LOCKED) ? lock_sel : sel;
    assign in_range = ({{(32-SEL_W){1'b0}}, active} < 32'(N_CH));
    // Ready is held low while reset is asserted so no beat is granted mid-reset.
    assign grant_ok = rst_n && in_range && free;
    assign hs       = grant_ok && sel_valid;
    assign busy     = (state == LOCKED);
    assign cur_sel  = active;

    for (genvar i = 0; i < N_CH; i++) begin : g_rdy
        assign s_ready[i] = grant_ok && (active == SEL_W'(i));
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (active == SEL_W'(i)) begin
                sel_valid = s_valid[i];
                sel_last  = s_last[i];
                sel_data  = s_data[ch_lo(i, DATA_W) +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hs && !sel_last) state_nx = LOCKED;
            LOCKED:  if (hs && sel_last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && hs && !sel_last) lock_sel <= sel;
        end
    end

    stream_reg_slice #(.W(DATA_W + 1)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (hs),
        .in_ready  (free),
        .in_data   ({sel_last, sel_data}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  ({m_last, m_data})
    );

endmodule
